alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits (>=4, power of two).
REQ-002 Port: Clk  in  1  single clock, all state on rising edge.
REQ-003 Port: Rst  in  1  reset, synchronous, active-high.
REQ-004 Port: Start  in  1  operation request.
REQ-005 Port: X  in  WIDTH  operand A.
REQ-006 Port: Y  in  WIDTH  operand B; shift amount = Y[log2(WIDTH)-1:0].
REQ-007 Port: Aluc  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 MUL.
REQ-008 Port: Busy  out  1  high while operation executing.
REQ-009 Port: Done  out  1  one-cycle pulse, R and flags valid.
REQ-010 Port: R  out  WIDTH  registered result.
REQ-011 Port: Z  out  1  R == 0.
REQ-012 Port: C  out  1  carry / last bit shifted out.
REQ-013 Port: V  out  1  signed overflow.
REQ-014 Port: N  out  1  R[WIDTH-1].

Function
REQ-015 FSM SHALL have states IDLE, EXEC, DONE; Busy = (state == EXEC).
REQ-016 Start SHALL be accepted only when Busy = 0 (IDLE or DONE); X, Y, Aluc latched at acceptance edge k.
REQ-017 Start while Busy = 1 SHALL be ignored; latched operands unchanged.
REQ-018 ADD/SUB/AND/OR/XOR SHALL complete with Done high in cycle k+1 (no EXEC cycle).
REQ-019 SUB SHALL compute X + ~Y + 1; C = carry-out of that sum (1 when X >= Y unsigned).
REQ-020 ADD C = carry-out; V = signed overflow for ADD/SUB; V = 0 for all other ops.
REQ-021 SLL/SRL SHALL shift one bit per EXEC cycle, zero fill; Done in cycle k+1+shamt; shamt = 0 gives R = X, C = 0, Done at k+1.
REQ-022 Shift C SHALL equal the last bit shifted out.
REQ-023 MUL SHALL be iterative shift-add, one multiplier bit per EXEC cycle, WIDTH cycles; R = low WIDTH bits of unsigned product; Done in cycle k+1+WIDTH.
REQ-024 AND/OR/XOR/MUL SHALL give C = 0.
REQ-025 Z and N SHALL be derived from the final R and update only with Done.
REQ-026 R and flags SHALL hold their values until the next Done.
REQ-027 Start accepted in the DONE cycle SHALL begin the next operation back-to-back.

Reset
REQ-028 Rst high at an edge SHALL force IDLE, Busy = 0, Done = 0, R = 0, Z = 1, C = V = N = 0.
REQ-029 Rst during EXEC SHALL abort the operation with no Done pulse; Start SHALL be accepted the cycle after Rst deasserts.
REQ-030 Rst SHALL override a simultaneous Start.

Configuration
REQ-031 Macro ALU_MC_MUL_EN defined: multiplier datapath present, Aluc = 111 behaves per REQ-023.
REQ-032 ALU_MC_MUL_EN undefined: no multiplier logic; Aluc = 111 completes at k+1 with R = 0, Z = 1, C = V = N = 0.

Verification (WIDTH = 32)
REQ-033 ADD X=0x7FFFFFFF, Y=1 -> Done at k+1, R=0x80000000, V=1, N=1, C=0, Z=0.
REQ-034 SUB X=5, Y=5 -> Done at k+1, R=0, Z=1, C=1, V=0; SUB X=0, Y=1 -> R=0xFFFFFFFF, C=0, N=1.
REQ-035 SLL X=1, Y=31 -> Busy for 31 cycles, Done at k+32, R=0x80000000, C=0; SRL X=3, Y=1 -> R=1, C=1, Done at k+2.
REQ-036 MUL X=0x0000FFFF, Y=0x00010001 with ALU_MC_MUL_EN -> Done at k+33, R=0xFFFFFFFF; without the macro -> Done at k+1, R=0, Z=1.
REQ-037 Start ADD pulsed during a MUL EXEC -> ignored, MUL result unaffected; Start issued in the DONE cycle -> accepted, Done at next cycle.
REQ-038 Rst asserted on the 3rd EXEC cycle of MUL -> no Done, R=0, Z=1, Busy=0; following ADD X=2, Y=3 -> R=5 at k+1.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: ADD/SUB/logic ops finish the cycle after Start, shifts take one cycle per bit, MUL takes WIDTH cycles.
// Latency 1 cycle for ADD/SUB/AND/OR/XOR; 1+shamt for SLL/SRL; 1+WIDTH for MUL. ALU_MC_MUL_EN enables the MUL datapath.
// Start is ignored while Busy is high. There is no output backpressure: Done is a one-cycle pulse.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [2:0]       Aluc,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] R,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic             N
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

    state_t           state;
    logic [2:0]       op;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             fin;
    logic [WIDTH-1:0] fin_r;
    logic             fin_c;
    logic             fin_v;
    logic [SW-1:0]    shamt;
    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;
`ifdef ALU_MC_MUL_EN
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_nxt;

    assign acc_nxt = mplier[0] ? acc + sreg : acc;
`endif

    assign shamt   = Y[SW-1:0];
    assign accept  = Start && (state != EXEC);
    assign sum_add = {1'b0, X} + {1'b0, Y};
    assign sum_sub = {1'b0, X} + {1'b0, ~Y} + {{WIDTH{1'b0}}, 1'b1};

    // fin marks the edge at which R and the flags are committed.
    always_comb begin
        fin   = 1'b0;
        fin_r = '0;
        fin_c = 1'b0;
        fin_v = 1'b0;
        if (state == EXEC) begin
            fin = (cnt == CW'(1));
            case (op)
                OP_SLL: begin
                    fin_r = sreg << 1;
                    fin_c = sreg[WIDTH-1];
                end
                OP_SRL: begin
                    fin_r = sreg >> 1;
                    fin_c = sreg[0];
                end
`ifdef ALU_MC_MUL_EN
                OP_MUL: fin_r = acc_nxt;
`endif
                default: fin_r = '0;
            endcase
        end else if (accept) begin
            case (Aluc)
                OP_ADD: begin
                    fin   = 1'b1;
                    fin_r = sum_add[WIDTH-1:0];
                    fin_c = sum_add[WIDTH];
                    fin_v = (X[WIDTH-1] == Y[WIDTH-1]) && (sum_add[WIDTH-1] != X[WIDTH-1]);
                end
                OP_SUB: begin
                    fin   = 1'b1;
                    fin_r = sum_sub[WIDTH-1:0];
                    fin_c = sum_sub[WIDTH];
                    fin_v = (X[WIDTH-1] != Y[WIDTH-1]) && (sum_sub[WIDTH-1] != X[WIDTH-1]);
                end
                OP_AND: begin
                    fin   = 1'b1;
                    fin_r = X & Y;
                end
                OP_OR: begin
                    fin   = 1'b1;
                    fin_r = X | Y;
                end
                OP_XOR: begin
                    fin   = 1'b1;
                    fin_r = X ^ Y;
                end
                OP_SLL, OP_SRL: begin
                    fin   = (shamt == '0);
                    fin_r = X;
                end
`ifdef ALU_MC_MUL_EN
                default: fin = 1'b0;
`else
                default: fin = 1'b1;
`endif
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            R     <= '0;
            Z     <= 1'b1;
            C     <= 1'b0;
            V     <= 1'b0;
            N     <= 1'b0;
            op    <= OP_ADD;
            sreg  <= '0;
            cnt   <= '0;
`ifdef ALU_MC_MUL_EN
            acc    <= '0;
            mplier <= '0;
`endif
        end else begin
            Done <= fin;
            Busy <= !fin && ((state == EXEC) || accept);
            if (fin) begin
                R <= fin_r;
                Z <= (fin_r == '0);
                C <= fin_c;
                V <= fin_v;
                N <= fin_r[WIDTH-1];
            end
            case (state)
                EXEC: begin
                    if (fin) state <= DONE;
                    cnt <= cnt - CW'(1);
                    // MUL also walks its multiplicand left through sreg.
                    if (op == OP_SRL) sreg <= sreg >> 1;
                    else              sreg <= sreg << 1;
`ifdef ALU_MC_MUL_EN
                    acc    <= acc_nxt;
                    mplier <= mplier >> 1;
`endif
                end
                default: begin
                    if (accept) begin
                        state <= fin ? DONE : EXEC;
                        op    <= Aluc;
                        sreg  <= X;
                        cnt   <= (Aluc == OP_MUL) ? CW'(WIDTH) : {1'b0, shamt};
`ifdef ALU_MC_MUL_EN
                        acc    <= '0;
                        mplier <= Y;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc at WIDTH = 32; latency counts edges from the accepting edge k (Done at k+n gives lat = n).
module tb_alu_mc;
    logic        Clk = 1'b0;
    logic        Rst, Start;
    logic [31:0] X, Y;
    logic [2:0]  Aluc;
    logic        Busy, Done, Z, C, V, N;
    logic [31:0] R;

    int tests = 0;
    int fails = 0;
    int lat, bcnt;
    logic seen;

    alu_mc #(.WIDTH(32)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .X(X), .Y(Y), .Aluc(Aluc),
        .Busy(Busy), .Done(Done), .R(R), .Z(Z), .C(C), .V(V), .N(N)
    );

    always #5 Clk = ~Clk;

    task start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        Start = 1'b1; Aluc = op; X = a; Y = b;
        @(posedge Clk); #1;
        Start = 1'b0;
        lat  = 1;
        bcnt = Busy ? 1 : 0;
    endtask

    task wait_done();
        while (!Done && lat < 200) begin
            @(posedge Clk); #1;
            lat++;
            if (Busy) bcnt++;
        end
    endtask

    task run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start_op(op, a, b);
        wait_done();
    endtask

    task test_reset();
        Rst = 1'b1; Start = 1'b0; X = '0; Y = '0; Aluc = '0;
        repeat (2) @(posedge Clk);
        #1;
        tests++; if ({Busy, Done, Z, C, V, N} !== 6'b001000) begin fails++; $display("FAIL reset_ctl_flags: got %b want 001000", {Busy, Done, Z, C, V, N}); end
        tests++; if (R !== 32'h0) begin fails++; $display("FAIL reset_r: got %h want 00000000", R); end
        Rst = 1'b0;
    endtask

    task test_add();
        run_op(3'b000, 32'h7FFF_FFFF, 32'h1);
        tests++; if (lat !== 1) begin fails++; $display("FAIL add_ovf_lat: got %0d want 1", lat); end
        tests++; if (R !== 32'h8000_0000) begin fails++; $display("FAIL add_ovf_r: got %h want 80000000", R); end
        tests++; if ({Z, C, V, N} !== 4'b0011) begin fails++; $display("FAIL add_ovf_zcvn: got %b want 0011", {Z, C, V, N}); end
        @(posedge Clk); #1;
        tests++; if (Done !== 1'b0) begin fails++; $display("FAIL add_done_pulse: got %b want 0", Done); end
        tests++; if (R !== 32'h8000_0000) begin fails++; $display("FAIL add_r_hold: got %h want 80000000", R); end
        run_op(3'b000, 32'hFFFF_FFFF, 32'h1);
        tests++; if ({R, Z, C, V, N} !== {32'h0, 4'b1100}) begin fails++; $display("FAIL add_carry: got %h %b want 00000000 1100", R, {Z, C, V, N}); end
    endtask

    task test_sub();
        run_op(3'b001, 32'd5, 32'd5);
        tests++; if (lat !== 1) begin fails++; $display("FAIL sub_eq_lat: got %0d want 1", lat); end
        tests++; if ({R, Z, C, V, N} !== {32'h0, 4'b1100}) begin fails++; $display("FAIL sub_eq: got %h %b want 00000000 1100", R, {Z, C, V, N}); end
        run_op(3'b001, 32'd0, 32'd1);
        tests++; if ({R, Z, C, V, N} !== {32'hFFFF_FFFF, 4'b0001}) begin fails++; $display("FAIL sub_borrow: got %h %b want ffffffff 0001", R, {Z, C, V, N}); end
        run_op(3'b001, 32'h8000_0000, 32'd1);
        tests++; if ({R, Z, C, V, N} !== {32'h7FFF_FFFF, 4'b0110}) begin fails++; $display("FAIL sub_ovf: got %h %b want 7fffffff 0110", R, {Z, C, V, N}); end
    endtask

    task test_logic();
        run_op(3'b010, 32'hF0F0_1234, 32'hFF00_FF00);
        tests++; if ({R, Z, C, V, N, lat[3:0]} !== {32'hF000_1200, 4'b0001, 4'd1}) begin fails++; $display("FAIL and: got %h %b lat %0d want f0001200 0001 lat 1", R, {Z, C, V, N}, lat); end
        run_op(3'b011, 32'h0F0F_0000, 32'h0000_00F0);
        tests++; if ({R, Z, C, V, N} !== {32'h0F0F_00F0, 4'b0000}) begin fails++; $display("FAIL or: got %h %b want 0f0f00f0 0000", R, {Z, C, V, N}); end
        run_op(3'b100, 32'h8000_0000, 32'h0000_0001);
        tests++; if ({R, Z, C, V, N} !== {32'h8000_0001, 4'b0001}) begin fails++; $display("FAIL xor: got %h %b want 80000001 0001", R, {Z, C, V, N}); end
    endtask

    task test_shift();
        run_op(3'b101, 32'h1, 32'd31);
        tests++; if (lat !== 32) begin fails++; $display("FAIL sll31_lat: got %0d want 32", lat); end
        tests++; if (bcnt !== 31) begin fails++; $display("FAIL sll31_busy: got %0d want 31", bcnt); end
        tests++; if ({R, C} !== {32'h8000_0000, 1'b0}) begin fails++; $display("FAIL sll31_r: got %h c=%b want 80000000 c=0", R, C); end
        run_op(3'b101, 32'hC000_0000, 32'd2);
        tests++; if ({R, Z, C, V, N, lat[3:0]} !== {32'h0, 4'b1100, 4'd3}) begin fails++; $display("FAIL sll_out: got %h %b lat %0d want 00000000 1100 lat 3", R, {Z, C, V, N}, lat); end
        run_op(3'b110, 32'h3, 32'd1);
        tests++; if ({R, C, lat[3:0]} !== {32'h1, 1'b1, 4'd2}) begin fails++; $display("FAIL srl1: got %h c=%b lat %0d want 00000001 c=1 lat 2", R, C, lat); end
        run_op(3'b101, 32'h0000_ABCD, 32'd32);
        tests++; if ({R, C, lat[3:0]} !== {32'h0000_ABCD, 1'b0, 4'd1}) begin fails++; $display("FAIL shamt0: got %h c=%b lat %0d want 0000abcd c=0 lat 1", R, C, lat); end
    endtask

    task test_mul();
        run_op(3'b111, 32'h0000_FFFF, 32'h0001_0001);
`ifdef ALU_MC_MUL_EN
        tests++; if (lat !== 33) begin fails++; $display("FAIL mul_lat: got %0d want 33", lat); end
        tests++; if ({R, Z, C, V, N} !== {32'hFFFF_FFFF, 4'b0001}) begin fails++; $display("FAIL mul_r: got %h %b want ffffffff 0001", R, {Z, C, V, N}); end
`else
        tests++; if (lat !== 1) begin fails++; $display("FAIL mul_off_lat: got %0d want 1", lat); end
        tests++; if ({R, Z, C, V, N} !== {32'h0, 4'b1000}) begin fails++; $display("FAIL mul_off_r: got %h %b want 00000000 1000", R, {Z, C, V, N}); end
`endif
    endtask

    task test_back_to_back();
`ifdef ALU_MC_MUL_EN
        start_op(3'b111, 32'd7, 32'd6);
`else
        start_op(3'b101, 32'd5, 32'd10);
`endif
        repeat (3) begin @(posedge Clk); #1; lat++; end
        @(negedge Clk);
        Start = 1'b1; Aluc = 3'b000; X = 32'd100; Y = 32'd200;
        @(posedge Clk); #1;
        lat++;
        Start = 1'b0;
        wait_done();
`ifdef ALU_MC_MUL_EN
        tests++; if ({R, lat[7:0]} !== {32'd42, 8'd33}) begin fails++; $display("FAIL busy_ignore: got %h lat %0d want 0000002a lat 33", R, lat); end
`else
        tests++; if ({R, lat[7:0]} !== {32'h1400, 8'd11}) begin fails++; $display("FAIL busy_ignore: got %h lat %0d want 00001400 lat 11", R, lat); end
`endif
        Start = 1'b1; Aluc = 3'b000; X = 32'd2; Y = 32'd3;
        @(posedge Clk); #1;
        Start = 1'b0;
        tests++; if ({Done, R} !== {1'b1, 32'd5}) begin fails++; $display("FAIL b2b: got done=%b r=%h want done=1 r=00000005", Done, R); end
        @(posedge Clk); #1;
        tests++; if (Done !== 1'b0) begin fails++; $display("FAIL b2b_pulse: got %b want 0", Done); end
    endtask

    task test_reset_abort();
`ifdef ALU_MC_MUL_EN
        start_op(3'b111, 32'h0000_FFFF, 32'h0001_0001);
`else
        start_op(3'b101, 32'd5, 32'd20);
`endif
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk); #1;
        tests++; if ({Busy, Done, Z, R} !== {3'b001, 32'h0}) begin fails++; $display("FAIL abort: got busy=%b done=%b z=%b r=%h want 0 0 1 00000000", Busy, Done, Z, R); end
        Rst = 1'b0;
        run_op(3'b000, 32'd2, 32'd3);
        tests++; if ({R, lat[3:0]} !== {32'd5, 4'd1}) begin fails++; $display("FAIL abort_add: got %h lat %0d want 00000005 lat 1", R, lat); end
        seen = 1'b0;
        repeat (40) begin @(posedge Clk); #1; if (Done) seen = 1'b1; end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL abort_stale_done: got %b want 0", seen); end
    endtask

    task test_rst_start();
        @(negedge Clk);
        Rst = 1'b1; Start = 1'b1; Aluc = 3'b000; X = 32'd4; Y = 32'd4;
        @(posedge Clk); #1;
        Rst = 1'b0; Start = 1'b0;
        tests++; if ({Busy, Done, R} !== {2'b00, 32'h0}) begin fails++; $display("FAIL rst_over_start: got busy=%b done=%b r=%h want 0 0 00000000", Busy, Done, R); end
        @(posedge Clk); #1;
        tests++; if ({Done, R} !== {1'b0, 32'h0}) begin fails++; $display("FAIL rst_over_start_late: got done=%b r=%h want 0 00000000", Done, R); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_shift();
        test_mul();
        test_back_to_back();
        test_reset_abort();
        test_rst_start();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
